// File: rtl/calc3_port_checker.sv
// Scoreboard-style checker for one Calc3 port: captures two-cycle requests, predicts
// the response per tag, and compares it against the DUT's response stream.
module calc3_port_checker #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_tag,
  input  logic [1:0]       out_resp,
  input  logic [31:0]      out_data,
  input  logic [1:0]       out_tag,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [1:0]       err_tag,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       outstanding
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, OP2} state_e;

  state_e state_q, state_d;
  logic   capture_en, write_en;

  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  tag_q, tag_d;
  logic [31:0] op1_q, op1_d;

  logic [3:0]       valid_q, valid_d;
  logic [1:0]       exp_resp_q [4];
  logic [1:0]       exp_resp_d [4];
  logic [31:0]      exp_data_q [4];
  logic [31:0]      exp_data_d [4];
  logic [AGE_W-1:0] age_q [4];
  logic [AGE_W-1:0] age_d [4];

  logic [1:0]  new_resp;
  logic [31:0] new_data;
  logic [32:0] sum;

  logic       resp_valid, resp_pass, dup_hit;
  logic [2:0] resp_code;
  logic [3:0] timeout_hit;
  logic [2:0] n_err;

  logic             err_pulse_q, err_pulse_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [1:0]       err_tag_q, err_tag_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W:0]   pass_sum, fail_sum;

  // Capture FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_cmd != 4'd0) state_d = OP2;
      OP2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == IDLE) && (req_cmd != 4'd0);
    write_en   = (state_q == OP2);
  end

  always_comb begin
    cmd_d = capture_en ? req_cmd  : cmd_q;
    tag_d = capture_en ? req_tag  : tag_q;
    op1_d = capture_en ? req_data : op1_q;
  end

  // Expected result uses the live req_data as operand 2 during OP2
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, req_data};
    new_resp = 2'b10;
    new_data = 32'd0;
    case (cmd_q)
      4'd1: begin
        new_data = sum[31:0];
        new_resp = sum[32] ? 2'b10 : 2'b01;
      end
      4'd2: begin
        new_data = op1_q - req_data;
        new_resp = (op1_q < req_data) ? 2'b10 : 2'b01;
      end
      4'd5: begin
        new_data = op1_q << req_data[4:0];
        new_resp = 2'b01;
      end
      4'd6: begin
        new_data = op1_q >> req_data[4:0];
        new_resp = 2'b01;
      end
      default: begin
        new_data = 32'd0;
        new_resp = 2'b10;
      end
    endcase
  end

  always_comb begin
    resp_valid = (out_resp != 2'b00);
    resp_code  = 3'd0;
    resp_pass  = 1'b0;
    if (resp_valid) begin
      if (!valid_q[out_tag])                                           resp_code = 3'd1;
      else if (out_resp != exp_resp_q[out_tag])                        resp_code = 3'd2;
      else if (out_resp == 2'b01 && out_data != exp_data_q[out_tag])   resp_code = 3'd3;
      else                                                             resp_pass = 1'b1;
    end
    dup_hit = write_en && valid_q[tag_q] && !(resp_valid && out_tag == tag_q);
  end

  // A response or a fresh write on the same tag pre-empts that tag's timeout
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid_d[i]     = valid_q[i];
      exp_resp_d[i]  = exp_resp_q[i];
      exp_data_d[i]  = exp_data_q[i];
      age_d[i]       = valid_q[i] ? age_q[i] + AGE_W'(1) : age_q[i];
      timeout_hit[i] = valid_q[i] && (age_q[i] == AGE_W'(TIMEOUT))
                       && !(resp_valid && out_tag == 2'(i))
                       && !(write_en && tag_q == 2'(i));
      if ((resp_valid && out_tag == 2'(i)) || timeout_hit[i]) valid_d[i] = 1'b0;
      if (write_en && tag_q == 2'(i)) begin
        valid_d[i]    = 1'b1;
        exp_resp_d[i] = new_resp;
        exp_data_d[i] = new_data;
        age_d[i]      = '0;
      end
    end
  end

  always_comb begin
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_tag_d   = err_tag_q;
    n_err       = 3'((resp_code != 3'd0)) + 3'(dup_hit);
    for (int i = 0; i < 4; i++) n_err = n_err + 3'(timeout_hit[i]);
    if (resp_code != 3'd0) begin
      err_pulse_d = 1'b1;
      err_code_d  = resp_code;
      err_tag_d   = out_tag;
    end else if (dup_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = 3'd5;
      err_tag_d   = tag_q;
    end else if (timeout_hit != 4'd0) begin
      err_pulse_d = 1'b1;
      err_code_d  = 3'd4;
      for (int i = 3; i >= 0; i--) if (timeout_hit[i]) err_tag_d = 2'(i);
    end
  end

  always_comb begin
    pass_sum   = {1'b0, pass_cnt_q} + (CNT_W+1)'(resp_pass);
    fail_sum   = {1'b0, fail_cnt_q} + (CNT_W+1)'(n_err);
    pass_cnt_d = pass_sum[CNT_W] ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    fail_cnt_d = fail_sum[CNT_W] ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= '0;
      tag_q       <= '0;
      op1_q       <= '0;
      valid_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_tag_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        exp_resp_q[i] <= '0;
        exp_data_q[i] <= '0;
        age_q[i]      <= '0;
      end
    end else begin
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      op1_q       <= op1_d;
      valid_q     <= valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_tag_q   <= err_tag_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      for (int i = 0; i < 4; i++) begin
        exp_resp_q[i] <= exp_resp_d[i];
        exp_data_q[i] <= exp_data_d[i];
        age_q[i]      <= age_d[i];
      end
    end
  end

  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign err_tag     = err_tag_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign outstanding = valid_q;

endmodule
